// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the main-memory port arbiter.
package mem_port_arbiter_pkg;

    // Transaction sequencer states: one memory access per IDLE->ISSUE->WAIT->DONE pass.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    // Identity of the requester that owns the transaction in flight.
    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_e;

    // Width of a counter that must hold values 0..max_val (never narrower than 1 bit).
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of DM grants taken while a fetch was waiting; flags when IF must be forced.
module arb_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_clear,
    output logic o_force_if
);

    localparam int CW = cnt_width(STARVE_LIMIT);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_force;

    // Next count: clear wins over increment, increment saturates at the limit.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clear) begin
            w_cnt_nxt = {CW{1'b0}};
        end else if (i_inc && (r_cnt != LIMIT_C)) begin
            w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Counter and its registered force flag, which tracks the count value being stored.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= {CW{1'b0}};
            r_force <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_force <= (w_cnt_nxt == LIMIT_C);
        end
    end

    assign o_force_if = r_force;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port synchronous main memory between instruction fetch and load/store.
// One transaction at a time; DM has priority, a starvation guard bounds how long IF waits.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_if_req,
    input  logic [ADDR_W-1:0]     i_if_addr,
    output logic                  o_if_done,
    output logic [DATA_W-1:0]     o_if_rdata,
    input  logic                  i_dm_req,
    input  logic                  i_dm_we,
    input  logic [DATA_W/8-1:0]   i_dm_be,
    input  logic [ADDR_W-1:0]     i_dm_addr,
    input  logic [DATA_W-1:0]     i_dm_wdata,
    output logic                  o_dm_done,
    output logic [DATA_W-1:0]     o_dm_rdata,
    output logic                  o_mem_en,
    output logic [DATA_W/8-1:0]   o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    input  logic [DATA_W-1:0]     i_mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = cnt_width(MEM_LAT);
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    arb_state_e          r_state;
    req_id_e             r_winner;
    logic                r_is_read;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_if_done;
    logic [DATA_W-1:0]   r_if_rdata;
    logic                r_dm_done;
    logic [DATA_W-1:0]   r_dm_rdata;
    logic                r_mem_en;
    logic [BE_W-1:0]     r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic w_idle;
    logic w_any_req;
    logic w_grant_if;
    logic w_force_if;
    logic w_starve_inc;
    logic w_starve_clr;

    // Arbitration is only evaluated in IDLE; requests in other states are not sampled.
    assign w_idle       = (r_state == ST_IDLE);
    assign w_any_req    = i_if_req | i_dm_req;
    assign w_grant_if   = i_if_req & (~i_dm_req | w_force_if);
    assign w_starve_inc = w_idle & i_dm_req & i_if_req & ~w_grant_if;
    assign w_starve_clr = w_idle & (~i_if_req | w_grant_if);

    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_inc      (w_starve_inc),
        .i_clear    (w_starve_clr),
        .o_force_if (w_force_if)
    );

    // Transaction sequencer: latches the winner's request, strobes memory once, waits out
    // the read latency, captures read data and pulses the winner's done for one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_winner    <= REQ_IF;
            r_is_read   <= 1'b0;
            r_cnt       <= {CNT_W{1'b0}};
            r_if_done   <= 1'b0;
            r_if_rdata  <= {DATA_W{1'b0}};
            r_dm_done   <= 1'b0;
            r_dm_rdata  <= {DATA_W{1'b0}};
            r_mem_en    <= 1'b0;
            r_mem_we    <= {BE_W{1'b0}};
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
        end else begin
            r_if_done <= 1'b0;
            r_dm_done <= 1'b0;
            r_mem_en  <= 1'b0;
            r_mem_we  <= {BE_W{1'b0}};
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_mem_en <= 1'b1;
                        r_state  <= ST_ISSUE;
                        if (w_grant_if) begin
                            r_winner   <= REQ_IF;
                            r_is_read  <= 1'b1;
                            r_mem_addr <= i_if_addr;
                        end else begin
                            r_winner    <= REQ_DM;
                            r_is_read   <= ~i_dm_we;
                            r_mem_addr  <= i_dm_addr;
                            r_mem_wdata <= i_dm_wdata;
                            r_mem_we    <= i_dm_we ? i_dm_be : {BE_W{1'b0}};
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= LAT_C;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == ONE_C) begin
                        r_state <= ST_DONE;
                        if (r_winner == REQ_IF) begin
                            r_if_done  <= 1'b1;
                            r_if_rdata <= i_mem_rdata;
                        end else begin
                            r_dm_done <= 1'b1;
                            if (r_is_read) begin
                                r_dm_rdata <= i_mem_rdata;
                            end else begin
                                r_dm_rdata <= r_dm_rdata;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - ONE_C;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_if_done   = r_if_done;
    assign o_if_rdata  = r_if_rdata;
    assign o_dm_done   = r_dm_done;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model (timestamps, shadow memory, starvation count).
module tb_mem_port_arbiter;

    localparam int LAT   = 1;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, init_mem;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [3:0]  dm_be;
    logic        if_done, dm_done, mem_en;
    logic [3:0]  mem_we;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    logic        dm_req3;
    logic [31:0] dm_addr3, mem_rdata3;
    logic        if_done3, dm_done3, mem_en3;
    logic [3:0]  mem_we3;
    logic [31:0] if_rdata3, dm_rdata3, mem_addr3, mem_wdata3;
    int          k3 = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_LIMIT(LIMIT)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_done(if_done), .o_if_rdata(if_rdata),
        .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_be(dm_be), .i_dm_addr(dm_addr),
        .i_dm_wdata(dm_wdata), .o_dm_done(dm_done), .o_dm_rdata(dm_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_LIMIT(LIMIT)) u_dut3 (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(1'b0), .i_if_addr(32'h0), .o_if_done(if_done3), .o_if_rdata(if_rdata3),
        .i_dm_req(dm_req3), .i_dm_we(1'b0), .i_dm_be(4'h0), .i_dm_addr(dm_addr3),
        .i_dm_wdata(32'h0), .o_dm_done(dm_done3), .o_dm_rdata(dm_rdata3),
        .o_mem_en(mem_en3), .o_mem_we(mem_we3), .o_mem_addr(mem_addr3), .o_mem_wdata(mem_wdata3),
        .i_mem_rdata(mem_rdata3)
    );

    // The slow memory returns a value that encodes the cycle it was presented in.
    assign mem_rdata3 = {16'hC0DE, k3[15:0]};

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 64) return 32'hDEADBEEF;
        if (i == 16) return 32'hA5A5A5A5;
        return 32'h5A000000 ^ (32'(i) * 32'h00010203);
    endfunction

    // Memory macro stand-in: byte-enable writes, read data valid LAT=1 cycle after mem_en, junk otherwise.
    logic [31:0] mem_arr [0:255];
    logic        rd_valid = 1'b0;
    logic [31:0] rd_data = 32'h0, junk = 32'h0;
    assign mem_rdata = rd_valid ? rd_data : junk;

    always @(posedge clk) begin
        junk     <= $urandom;
        rd_valid <= mem_en;
        rd_data  <= mem_arr[mem_addr[9:2]];
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
        end
        for (int b = 0; b < 4; b++) begin
            if (mem_en && mem_we[b]) mem_arr[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference model: a request seen while free is granted at cycle c, strobes memory at c+1
    // and completes at c+2+LAT; the port is free again after the completion cycle.
    int          cyc = 0, en_cyc = -1, done_cyc = -1, starve = 0;
    logic        m_if = 1'b0, m_read = 1'b0;
    logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_rd = 32'h0;
    logic [3:0]  m_we = 4'h0;
    logic [31:0] shadow [0:255];
    logic        e_if_done = 1'b0, e_dm_done = 1'b0, e_mem_en = 1'b0;
    logic [3:0]  e_mem_we = 4'h0;
    logic [31:0] e_if_rdata = 32'h0, e_dm_rdata = 32'h0, e_mem_addr = 32'h0, e_mem_wdata = 32'h0;

    initial begin
        forever begin
            @(posedge clk);
            if (init_mem) for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
            if (rst) begin
                starve = 0; en_cyc = -1; done_cyc = -1;
                e_if_done = 1'b0; e_dm_done = 1'b0; e_mem_en = 1'b0; e_mem_we = 4'h0;
                e_if_rdata = 32'h0; e_dm_rdata = 32'h0; e_mem_addr = 32'h0; e_mem_wdata = 32'h0;
            end else begin
                if (cyc > done_cyc) begin
                    if (!if_req) starve = 0;
                    if (if_req || dm_req) begin
                        m_if = if_req && (!dm_req || starve == LIMIT);
                        if (m_if) starve = 0;
                        else if (if_req) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
                        en_cyc   = cyc + 1;
                        done_cyc = cyc + 2 + LAT;
                        m_addr   = m_if ? if_addr : dm_addr;
                        m_read   = m_if || !dm_we;
                        m_we     = m_read ? 4'h0 : dm_be;
                        if (!m_if) m_wdata = dm_wdata;
                        m_rd = shadow[m_addr[9:2]];
                        for (int b = 0; b < 4; b++)
                            if (m_we[b]) shadow[m_addr[9:2]][8*b +: 8] = dm_wdata[8*b +: 8];
                    end
                end
                e_mem_en  = (cyc + 1 == en_cyc);
                e_mem_we  = e_mem_en ? m_we : 4'h0;
                if (e_mem_en) begin
                    e_mem_addr = m_addr;
                    if (!m_if) e_mem_wdata = m_wdata;
                end
                e_if_done = (cyc + 1 == done_cyc) && m_if;
                e_dm_done = (cyc + 1 == done_cyc) && !m_if;
                if (e_if_done) e_if_rdata = m_rd;
                if (e_dm_done && m_read) e_dm_rdata = m_rd;
            end
            cyc++;
        end
    end

    // Compare process: every output of the main instance, every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                check("if_done",   if_done,   e_if_done);
                check("dm_done",   dm_done,   e_dm_done);
                check("if_rdata",  if_rdata,  e_if_rdata);
                check("dm_rdata",  dm_rdata,  e_dm_rdata);
                check("mem_en",    mem_en,    e_mem_en);
                check("mem_we",    mem_we,    e_mem_we);
                check("mem_addr",  mem_addr,  e_mem_addr);
                check("mem_wdata", mem_wdata, e_mem_wdata);
                check("done_excl", if_done & dm_done, 1'b0);
            end
        end
    end

    // Wait for a done pulse (0 = IF, 1 = DM); n = number of negedges waited.
    task automatic wait_for(input int which, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((which == 0) ? if_done : dm_done) && n < 40);
        check("done_seen", (which == 0) ? if_done : dm_done, 1'b1);
    endtask

    task automatic rand_dm();
        dm_we    = 1'($urandom_range(0, 1));
        dm_be    = 4'($urandom_range(0, 15));
        dm_addr  = 32'($urandom_range(0, 255)) << 2;
        dm_wdata = $urandom;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n, g, kr, ken, kd;
        logic [31:0] got3, exp3;
        rst = 1'b1; init_mem = 1'b1;
        if_req = 1'b1; if_addr = 32'h200;
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'h0; dm_addr = 32'h300; dm_wdata = 32'h0;
        dm_req3 = 1'b0; dm_addr3 = 32'h0;

        // Reset held three cycles with both requests high: nothing issues.
        repeat (3) begin
            @(negedge clk);
            init_mem = 1'b0;
            check("rst_mem_en", mem_en, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("first_grant_en", mem_en, 1'b1);
        check("first_grant_dm", mem_addr, 32'h300);
        wait_for(1, n);
        check("first_dm_lat", n, 2);
        dm_req = 1'b0;
        wait_for(0, n);
        check("if_after_dm_lat", n, 4);
        if_req = 1'b0;
        repeat (2) @(negedge clk);

        // Lone fetch of 0x100.
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        check("fetch_en", mem_en, 1'b1);
        wait_for(0, n);
        check("fetch_lat", n + 1, 3);
        check("fetch_data", if_rdata, 32'hDEADBEEF);
        check("fetch_model", e_if_rdata, 32'hDEADBEEF);
        if_req = 1'b0;
        repeat (2) @(negedge clk);

        // Partial store then load of the same word.
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h40; dm_wdata = 32'h12345678;
        @(negedge clk);
        check("store_we", mem_we, 4'b0011);
        wait_for(1, n);
        check("store_lat", n + 1, 3);
        dm_we = 1'b0;
        wait_for(1, n);
        check("load_lat", n, 4);
        check("load_data", dm_rdata, 32'hA5A55678);
        check("load_model", e_dm_rdata, 32'hA5A55678);
        dm_req = 1'b0;
        repeat (2) @(negedge clk);

        // Contention: both held; DM x4 then a forced IF, repeating.
        if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        g = 0;
        for (int c = 0; c < 100 && g < 10; c++) begin
            @(negedge clk);
            if (mem_en) begin
                check($sformatf("grant%0d_is_if", g), mem_addr == 32'h200, (g % 5) == 4);
                g++;
            end
        end
        check("grant_count", g, 10);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (if_done || dm_done) begin
                if_req = 1'b0; dm_req = 1'b0;
                break;
            end
        end
        repeat (3) @(negedge clk);

        // Reset during WAIT abandons the load silently.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        repeat (2) @(negedge clk);
        rst = 1'b1; dm_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_no_done", dm_done, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        dm_req = 1'b1; dm_addr = 32'h100;
        wait_for(1, n);
        check("post_rst_lat", n, 3);
        check("post_rst_data", dm_rdata, 32'hDEADBEEF);
        dm_req = 1'b0;
        repeat (2) @(negedge clk);

        // Three-cycle memory: done at R+5, data from the cycle three after mem_en.
        @(negedge clk); k3++;
        dm_req3 = 1'b1; dm_addr3 = 32'h44; kr = k3; ken = -100; kd = -100; got3 = 32'h0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); k3++;
            check("lat3_no_if", if_done3, 1'b0);
            if (mem_en3) ken = k3;
            if (dm_done3) begin
                kd = k3; got3 = dm_rdata3;
                break;
            end
        end
        dm_req3 = 1'b0;
        check("lat3_en", ken - kr, 1);
        check("lat3_done", kd - kr, 5);
        exp3 = {16'hC0DE, 16'(ken + 3)};
        check("lat3_data", got3, exp3);

        // Random traffic from both requesters.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (if_req && if_done) begin
                if ($urandom_range(0, 1) == 0) if_req = 1'b0;
                else if_addr = 32'($urandom_range(0, 255)) << 2;
            end else if (!if_req && $urandom_range(0, 3) == 0) begin
                if_req = 1'b1; if_addr = 32'($urandom_range(0, 255)) << 2;
            end
            if (dm_req && dm_done) begin
                if ($urandom_range(0, 1) == 0) dm_req = 1'b0;
                else rand_dm();
            end else if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1'b1; rand_dm();
            end
        end
        for (int c = 0; c < 80 && (if_req || dm_req); c++) begin
            @(negedge clk);
            if (if_done) if_req = 1'b0;
            if (dm_done) dm_req = 1'b0;
        end
        check("drained", {if_req, dm_req}, 2'b00);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
